// File: rtl/par_to_ser.sv
// par_to_ser: parallel-in, serial-out converter for the single-bit serial link.
//
// Takes a WIDTH-bit word on a valid/ready handshake and sends it one bit per
// accepted beat on a serial valid/ready stream. The final bit of each word is
// flagged with ser_last_o. A new word may be accepted on the same edge that
// transfers the final bit of the current word, so back-to-back words stream
// with no idle cycle.
//
// Parameters:
//   WIDTH     - word width in bits (>= 2)
//   MSB_FIRST - 0: bit 0 is sent first; 1: bit WIDTH-1 is sent first
//
// Ports:
//   clk         - rising-edge clock
//   reset       - asynchronous reset, active low
//   in_valid_i  - producer has a word on in_data_i
//   in_data_i   - parallel word
//   in_ready_o  - word is accepted this cycle if in_valid_i is high
//   ser_valid_o - ser_data_o holds a valid bit
//   ser_data_o  - current serial bit
//   ser_last_o  - current bit is the final bit of the word
//   ser_ready_i - consumer accepts the current bit
module par_to_ser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             ser_valid_o,
  output logic             ser_data_o,
  output logic             ser_last_o,
  input  logic             ser_ready_i
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic             out_bit;
  logic             at_last;
  logic [WIDTH-1:0] shifted;

  // Bit currently at the output end of the shift register.
  assign out_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

  // Shift toward the output end with zero fill.
  assign shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                             : {1'b0, shreg_q[WIDTH-1:1]};

  assign at_last = (state_q == SHIFT) && (cnt_q == LAST_IDX);

  // Outputs are gated by state so IDLE always shows a clean, quiet stream.
  assign ser_valid_o = (state_q == SHIFT);
  assign ser_data_o  = (state_q == SHIFT) ? out_bit : 1'b0;
  assign ser_last_o  = at_last;

  // Ready is also raised while the last bit is being taken, which lets the
  // next word load on the same edge (combinational path from ser_ready_i).
  assign in_ready_o = (state_q == IDLE) || (at_last && ser_ready_i);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          shreg_d = in_data_i;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_ready_i) begin
          if (!at_last) begin
            shreg_d = shifted;
            cnt_d   = cnt_q + CNT_W'(1);
          end else if (in_valid_i) begin
            // Word done and the next one is waiting: reload with no bubble.
            shreg_d = in_data_i;
            cnt_d   = '0;
          end else begin
            shreg_d = shifted;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
